pool_out_buffer: RTL and testbench
==================================

POOL_OUT_BUFFER -- requirements
Module: pool_out_buffer

Interface
REQ-001 Parameter N, default 16, width of one pooled pixel.
REQ-002 Parameter M, default 26, input feature-map side length in pixels.
REQ-003 Parameter P, default 2, pooling window side.
REQ-004 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, >= 2.
REQ-005 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 master_rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  pooled pixel present; driven by the pooling stage's op_en.
REQ-008 in_data  in  N  pooled pixel value.
REQ-009 clr_ovf  in  1  clears the sticky overflow flag.
REQ-010 out_ready  in  1  consumer accepts out_data this cycle.
REQ-011 out_valid  out  1  out_data/out_row/out_col/out_last are valid.
REQ-012 out_data  out  N  pooled pixel.
REQ-013 out_row, out_col  out  4 each  position in the pooled map, 0..M/P-1.
REQ-014 out_last  out  1  high when out_row = out_col = M/P-1.
REQ-015 frame_done  out  1  one-cycle pulse when an out_last word is transferred.
REQ-016 full, empty  out  1 each  FIFO status.
REQ-017 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-018 overflow  out  1  sticky; set when a word was dropped.
REQ-019 frame_count  out  8  completed frames read out, wraps 255->0.

Function
REQ-020 Write-side counters wr_col, wr_row SHALL advance on every in_valid, whether or not the word is stored: wr_col wraps M/P-1->0 and increments wr_row; wr_row wraps M/P-1->0.
REQ-021 On in_valid with full=0, {wr_row, wr_col, in_data} SHALL be written to the FIFO.
REQ-022 On in_valid with full=1, the word SHALL be dropped and overflow set next cycle. full is evaluated on pre-edge occupancy, so a read in the same cycle does not admit the write.
REQ-023 A transfer SHALL occur when out_valid and out_ready are both high. The head entry advances on the following edge.
REQ-024 out_valid SHALL equal !empty. Outputs SHALL present the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Latency: a word written into an empty FIFO SHALL appear with out_valid=1 on the cycle after the write edge. There is no bypass.
REQ-026 Simultaneous write and read with 0 < level < DEPTH: level unchanged, both pointers advance.
REQ-027 Pointers SHALL wrap modulo DEPTH. full = (level == DEPTH), empty = (level == 0).
REQ-028 frame_done SHALL pulse for exactly one cycle, registered, on the cycle after an out_last transfer. frame_count SHALL increment in the same cycle.
REQ-029 clr_ovf SHALL clear overflow. If a drop occurs in the same cycle, set wins.
REQ-030 Counter arithmetic SHALL be unsigned with explicit widths, with no 32-bit integers.

Reset
REQ-031 With master_rst=1 at an edge:
- pointers, level, wr_row, wr_col, frame_count, overflow and frame_done SHALL be 0;
- out_valid=0, empty=1, full=0.
REQ-032 Reset SHALL win over any simultaneous in_valid, transfer or clr_ovf. FIFO contents need not be cleared, but SHALL never be presented after reset.
REQ-033 Reset asserted mid-frame SHALL restart positions at (0,0) and discard all queued words.

Structure
REQ-034 Shared package pool_pkg SHALL hold M, P, POOL_DIM = M/P, pixel width N, and the position width (4).
REQ-035 Storage SHALL be one sub-module, pool_fifo: synchronous FIFO of width N+8 and depth DEPTH. Position tagging, overflow and frame logic SHALL live in pool_out_buffer.

Verification
REQ-036 Reset, then stream 169 words 0..168 with out_ready=1. Expect 169 transfers in order, positions (0,0)..(12,12), out_last only on value 168, one frame_done pulse, frame_count=1, overflow=0.
REQ-037 out_ready=0, write 20 words. Expect full=1 after 16 writes, level=16, overflow=1, words 16..19 dropped. Then read: values 0..15; the next frame's positions stay aligned.
REQ-038 FIFO at level 16, in_valid and transfer in the same cycle. Expect the write dropped, overflow set, level 15.
REQ-039 Empty FIFO, write one word at cycle t. Expect out_valid=1 at t+1. Hold out_ready=0 for 5 cycles: outputs stable.
REQ-040 Set overflow, then assert clr_ovf together with a new drop: overflow stays 1. Assert clr_ovf alone next cycle: overflow becomes 0.
REQ-041 Assert master_rst after 50 words of a frame: empty=1 next cycle, and the next write is tagged (0,0).

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants for the pooled-output buffer: map geometry, pixel and position widths.
package pool_pkg;
  localparam int PIX_W    = 16;
  localparam int MAP_M    = 26;
  localparam int POOL_P   = 2;
  localparam int POOL_DIM = MAP_M / POOL_P;
  localparam int POS_W    = 4;
endpackage

// File: rtl/pool_fifo.sv
// Synchronous FIFO; head entry is presented combinationally while not empty.
module pool_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // full/empty come from pre-edge occupancy, so a same-cycle read never admits a write
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/pool_out_buffer.sv
// Tags pooled pixels with their map position, queues them, and tracks overflow and frames.
module pool_out_buffer
  import pool_pkg::*;
#(
  parameter int N     = PIX_W,
  parameter int M     = MAP_M,
  parameter int P     = POOL_P,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     master_rst,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  input  logic                     clr_ovf,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [N-1:0]             out_data,
  output logic [POS_W-1:0]         out_row,
  output logic [POS_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               frame_count
);
  localparam int EW = N + 2*POS_W;
  localparam logic [POS_W-1:0] LAST = POS_W'(M/P - 1);

  logic [POS_W-1:0] wr_row, wr_col;
  logic [EW-1:0]    head;
  logic             xfer;

  pool_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (master_rst),
    .wr_en   (in_valid),
    .wr_data ({wr_row, wr_col, in_data}),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign out_valid = !empty;
  assign {out_row, out_col, out_data} = head;
  assign out_last  = out_valid && (out_row == LAST) && (out_col == LAST);
  assign xfer      = out_valid && out_ready;

  // positions advance even on dropped words so later frames stay aligned
  always_ff @(posedge clk) begin
    if (master_rst) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (in_valid) begin
      if (wr_col == LAST) begin
        wr_col <= '0;
        wr_row <= (wr_row == LAST) ? '0 : wr_row + 1'b1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      if (in_valid && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
      frame_done <= xfer && out_last;
      if (xfer && out_last) frame_count <= frame_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pool_out_buffer.sv
// Randomised and directed bench for pool_out_buffer against a queue-based reference model.
module tb_pool_out_buffer;
  localparam int DIM   = 13;
  localparam int DEPTH = 16;

  logic        clk = 0;
  logic        master_rst, in_valid, clr_ovf, out_ready;
  logic [15:0] in_data;
  logic        out_valid, out_last, frame_done, full, empty, overflow;
  logic [15:0] out_data;
  logic [3:0]  out_row, out_col;
  logic [4:0]  level;
  logic [7:0]  frame_count;

  pool_out_buffer #(.N(16), .M(26), .P(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .master_rst(master_rst), .in_valid(in_valid), .in_data(in_data),
    .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .frame_done(frame_done),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int r; int c; } ent_t;
  ent_t q[$];
  int   m_pidx = 0, m_fc = 0, n_fd = 0;
  bit   m_ovf = 0, m_fd = 0, chk_en = 0;
  int   errors = 0, checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of tagged words, position as a linear index into the map
  always @(posedge clk) begin
    if (master_rst) begin
      q.delete(); m_pidx = 0; m_fc = 0; m_ovf = 0; m_fd = 0;
    end else begin
      automatic bit fire = (q.size() > 0) && out_ready;
      automatic bit was_full = (q.size() == DEPTH);
      automatic bit drop = in_valid && was_full;
      automatic bit last = fire && q[0].r == DIM-1 && q[0].c == DIM-1;
      automatic ent_t e;
      if (fire) void'(q.pop_front());
      if (in_valid && !was_full) begin
        e.d = int'(in_data); e.r = m_pidx / DIM; e.c = m_pidx % DIM;
        q.push_back(e);
      end
      if (in_valid) m_pidx = (m_pidx + 1) % (DIM*DIM);
      if (drop) m_ovf = 1; else if (clr_ovf) m_ovf = 0;
      m_fd = last;
      if (last) m_fc = (m_fc + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", int'(out_valid), int'(q.size() > 0));
      check("empty", int'(empty), int'(q.size() == 0));
      check("full", int'(full), int'(q.size() == DEPTH));
      check("level", int'(level), q.size());
      check("overflow", int'(overflow), int'(m_ovf));
      check("frame_done", int'(frame_done), int'(m_fd));
      check("frame_count", int'(frame_count), m_fc);
      if (q.size() > 0) begin
        check("out_data", int'(out_data), q[0].d);
        check("out_row", int'(out_row), q[0].r);
        check("out_col", int'(out_col), q[0].c);
        check("out_last", int'(out_last), int'(q[0].r == DIM-1 && q[0].c == DIM-1));
      end
      if (frame_done) n_fd++;
    end
  end

  task automatic cyc(input bit iv, input int d, input bit rdy, input bit clr, input bit rst);
    in_valid = iv; in_data = 16'(d); out_ready = rdy; clr_ovf = clr; master_rst = rst;
    @(negedge clk);
  endtask

  initial begin
    in_valid = 0; in_data = 0; out_ready = 0; clr_ovf = 0; master_rst = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    chk_en = 1;
    check("rst_empty", int'(empty), 1);
    check("rst_level", int'(level), 0);
    check("rst_fc", int'(frame_count), 0);

    // full frame streamed straight through
    for (int i = 0; i < 169; i++) cyc(1, i, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    check("frame1_count", int'(frame_count), 1);
    check("frame1_pulses", n_fd, 1);
    check("frame1_ovf", int'(overflow), 0);

    // overfill with the consumer stalled
    for (int i = 0; i < 20; i++) cyc(1, i, 0, 0, 0);
    check("fill_level", int'(level), 16);
    check("fill_full", int'(full), 1);
    check("fill_ovf", int'(overflow), 1);
    check("fill_head", int'(out_data), 0);
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0, 0);
    check("drained", int'(empty), 1);

    // write and read against a full FIFO in one cycle
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 100 + i, 0, 0, 0);
    check("pre_ovf", int'(overflow), 0);
    cyc(1, 999, 1, 0, 0);
    check("rw_full_level", int'(level), 15);
    check("rw_full_ovf", int'(overflow), 1);

    // set beats clear
    cyc(1, 200, 0, 0, 0);
    cyc(1, 201, 0, 1, 0);
    check("clr_vs_drop", int'(overflow), 1);
    cyc(0, 0, 0, 1, 0);
    check("clr_alone", int'(overflow), 0);
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0, 0);

    // single-word latency and stall stability
    cyc(1, 16'h1234, 0, 0, 0);
    check("lat_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", int'(out_data), 16'h1234);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 0);

    // reset mid-frame
    for (int i = 0; i < 50; i++) cyc(1, i, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    check("midrst_empty", int'(empty), 1);
    cyc(1, 77, 0, 0, 0);
    check("midrst_row", int'(out_row), 0);
    check("midrst_col", int'(out_col), 0);
    check("midrst_data", int'(out_data), 77);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 60, int'($urandom_range(65535)), $urandom_range(99) < 50,
          $urandom_range(99) < 5, $urandom_range(999) < 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
